// File: rtl/sc_spi_pkg.sv
// Shared definitions for the two-requester SPI engine arbiter: state encoding,
// requester count and default completion-timeout settings.
package sc_spi_pkg;

  localparam int unsigned NREQ        = 2;
  localparam int unsigned TMO_W_DEF   = 16;
  localparam logic [15:0] TMO_MAX_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    START,
    WAIT,
    RESP
  } state_t;

  // Index of the owner encoded in a one-hot grant vector.
  function automatic logic owner_of(input logic [NREQ-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/sc_spi_rrsel.sv
// Two-way round-robin selector: the requester named by ptr wins a tie,
// otherwise whichever single requester is active is chosen.
module sc_spi_rrsel
  import sc_spi_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            ptr,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/sc_spi_arb.sv
// Arbitrates two word-streaming requesters onto one SPI engine; a granted
// requester keeps the engine (CS held) until its LAST word or a timeout.
module sc_spi_arb
  import sc_spi_pkg::*;
#(
  parameter int unsigned      TMO_W   = TMO_W_DEF,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_MAX_DEF
) (
  input  logic                 SYSCLK,
  input  logic                 SYSRST,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ-1:0]      REQ_LAST,
  input  logic [NREQ*32-1:0]   REQ_TXDATA,
  output logic [NREQ-1:0]      RSP_VALID,
  output logic [31:0]          RSP_RXDATA,
  output logic                 RSP_ERR,
  output logic [NREQ-1:0]      GRANT,
  output logic                 ENG_TXSTART,
  output logic                 ENG_CSEXTEND,
  output logic [31:0]          ENG_TXDATA,
  input  logic                 ENG_SPIBUSY,
  input  logic                 ENG_SPICOMPLETE,
  input  logic [31:0]          ENG_RXDATA
);

  state_t           state_q, state_d;
  logic             ptr_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  sel;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_inc;
  logic             tmo_hit;
  logic             owner;
  logic [31:0]      tx_word;
  logic             release_grant;

  sc_spi_rrsel u_rrsel (
    .req   (REQ_VALID),
    .ptr   (ptr_q),
    .grant (sel)
  );

  assign GRANT         = grant_q;
  assign owner         = owner_of(grant_q);
  assign tx_word       = owner ? REQ_TXDATA[63:32] : REQ_TXDATA[31:0];
  assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit       = (cnt_inc >= TMO_MAX);
  assign release_grant = !ENG_CSEXTEND || RSP_ERR;

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    REQ_READY   = '0;
    RSP_VALID   = '0;
    ENG_TXSTART = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|REQ_VALID) state_d = ACCEPT;
      end
      ACCEPT: begin
        REQ_READY = grant_q;
        if (REQ_VALID[owner]) state_d = START;
      end
      START: begin
        ENG_TXSTART = !ENG_SPIBUSY;
        if (!ENG_SPIBUSY) state_d = WAIT;
      end
      WAIT: begin
        if (ENG_SPICOMPLETE || tmo_hit) state_d = RESP;
      end
      RESP: begin
        RSP_VALID = grant_q;
        state_d   = release_grant ? IDLE : ACCEPT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      ptr_q        <= 1'b0;
      grant_q      <= '0;
      cnt_q        <= '0;
      RSP_RXDATA   <= '0;
      RSP_ERR      <= 1'b0;
      ENG_CSEXTEND <= 1'b0;
      ENG_TXDATA   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|REQ_VALID) grant_q <= sel;
        end
        ACCEPT: begin
          if (REQ_VALID[owner]) begin
            ENG_TXDATA   <= tx_word;
            ENG_CSEXTEND <= !REQ_LAST[owner];
          end
        end
        START: begin
          // The TXSTART cycle itself counts, so the response lands exactly
          // TMO_MAX cycles after the start pulse on a timeout.
          cnt_q <= ENG_SPIBUSY ? '0 : TMO_W'(1);
        end
        WAIT: begin
          cnt_q <= cnt_inc;
          if (ENG_SPICOMPLETE) begin
            RSP_RXDATA <= ENG_RXDATA;
            RSP_ERR    <= 1'b0;
          end else if (tmo_hit) begin
            RSP_RXDATA   <= '0;
            RSP_ERR      <= 1'b1;
            ENG_CSEXTEND <= 1'b0;
          end
        end
        RESP: begin
          if (release_grant) begin
            grant_q <= '0;
            ptr_q   <= ~owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
